ahb_lite_arb2: RTL and testbench



---
 rtl/ahb_lite_pkg.sv | 21 ++
 rtl/ahb_req_buf.sv | 88 ++++++++
 rtl/ahb_lite_arb2.sv | 210 +++++++++++++++++++++
 tb/tb_ahb_lite_arb2.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-lite definitions for the two-master arbiter.
//   HTRANS_*  : AHB transfer type encodings
//   owner_e   : bus-phase owner encoding (none / M0 / M1)
//   AHB_AW/DW : default address and data widths
package ahb_lite_pkg;

    localparam int unsigned AHB_AW = 32;
    localparam int unsigned AHB_DW = 64;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

endpackage

// File: rtl/ahb_req_buf.sv
// ahb_req_buf: per-master request buffer.
// Holds the address phase of a request that could not be granted in the cycle
// the master presented it, and stalls that master until the buffered request
// is issued. Presents either the buffered or the live address phase.
//   HCLK, HRESETn        : clock, async active-low reset
//   live_h*              : master's live address phase inputs
//   live_hready          : the master's private HREADY (as seen by the master)
//   granted              : this master wins the bus this cycle
//   pend                 : a buffered request is waiting
//   req                  : request to the arbiter (buffered or live)
//   aph_h*               : address phase to issue (buffered when pend)
module ahb_req_buf
    import ahb_lite_pkg::*;
#(
    parameter int unsigned AW = AHB_AW
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] live_haddr,
    input  logic [1:0]    live_htrans,
    input  logic          live_hwrite,
    input  logic [2:0]    live_hsize,
    input  logic          live_hready,
    input  logic          granted,
    output logic          pend,
    output logic          req,
    output logic [AW-1:0] aph_haddr,
    output logic          aph_hwrite,
    output logic [2:0]    aph_hsize
);

    logic          pend_q,  pend_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic          active;
    logic          live_req;

    // BUSY is treated as IDLE; SEQ counts as a fresh request.
    always_comb begin
        active = 1'b0;
        case (live_htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
    end

    assign live_req = active & live_hready;
    assign pend     = pend_q;
    assign req      = pend_q | live_req;

    assign aph_haddr  = pend_q ? haddr_q  : live_haddr;
    assign aph_hwrite = pend_q ? hwrite_q : live_hwrite;
    assign aph_hsize  = pend_q ? hsize_q  : live_hsize;

    always_comb begin
        pend_d   = pend_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        if (pend_q) begin
            if (granted) begin
                pend_d = 1'b0;
            end
        end else if (live_req && !granted) begin
            pend_d   = 1'b1;
            haddr_d  = live_haddr;
            hwrite_d = live_hwrite;
            hsize_d  = live_hsize;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q   <= 1'b0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
        end
    end

endmodule

// File: rtl/ahb_lite_arb2.sv
// ahb_lite_arb2: two-master AHB-lite arbiter (M0 = LSU, M1 = IFU) feeding one
// AHB-lite master port. A losing master's address phase is buffered and the
// master is stalled via its private HREADY until its transfer completes.
//   HCLK, HRESETn           : clock, async active-low reset
//   Mx_HADDR/HTRANS/HWRITE/HSIZE/HWDATA : master x request inputs
//   Mx_HREADY/HRDATA/HRESP  : master x responses (HRESP always OKAY)
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA    : to the bus
//   HREADY, HRDATA          : merged bus ready / read data
// Build option ARB_RR_EN: round-robin between same-class requests
// (otherwise fixed priority M0 > M1). Buffered requests always beat live ones.
module ahb_lite_arb2
    import ahb_lite_pkg::*;
#(
    parameter int unsigned AW = AHB_AW,
    parameter int unsigned DW = AHB_DW
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    output logic          M0_HRESP,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic          M1_HRESP,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [DW-1:0] HRDATA
);

    owner_e        data_owner_q, data_owner_d;
    logic [AW-1:0] haddr_q,  haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q,  hsize_d;

    logic          pend0, pend1, req0, req1;
    logic [AW-1:0] aph_haddr0, aph_haddr1;
    logic          aph_hwrite0, aph_hwrite1;
    logic [2:0]    aph_hsize0, aph_hsize1;
    logic          cls0, cls1, gnt0, gnt1;

    logic [AW-1:0] bus_haddr;
    logic [1:0]    bus_htrans;
    logic          bus_hwrite;
    logic [2:0]    bus_hsize;

`ifdef ARB_RR_EN
    owner_e        rr_last_q, rr_last_d;
`endif

    ahb_req_buf #(.AW(AW)) u_buf0 (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .live_haddr  (M0_HADDR),
        .live_htrans (M0_HTRANS),
        .live_hwrite (M0_HWRITE),
        .live_hsize  (M0_HSIZE),
        .live_hready (M0_HREADY),
        .granted     (gnt0),
        .pend        (pend0),
        .req         (req0),
        .aph_haddr   (aph_haddr0),
        .aph_hwrite  (aph_hwrite0),
        .aph_hsize   (aph_hsize0)
    );

    ahb_req_buf #(.AW(AW)) u_buf1 (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .live_haddr  (M1_HADDR),
        .live_htrans (M1_HTRANS),
        .live_hwrite (M1_HWRITE),
        .live_hsize  (M1_HSIZE),
        .live_hready (M1_HREADY),
        .granted     (gnt1),
        .pend        (pend1),
        .req         (req1),
        .aph_haddr   (aph_haddr1),
        .aph_hwrite  (aph_hwrite1),
        .aph_hsize   (aph_hsize1)
    );

    // Private HREADY depends only on registered state, so there is no
    // combinational path from the grant back into the requests.
    assign M0_HREADY = (data_owner_q == OWN_M0) ? HREADY : ~pend0;
    assign M1_HREADY = (data_owner_q == OWN_M1) ? HREADY : ~pend1;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HRESP  = 1'b0;
    assign M1_HRESP  = 1'b0;

    // Any buffered request puts the arbitration into the pending class, so
    // live requests cannot starve a buffered one.
    always_comb begin
        cls0 = (pend0 | pend1) ? pend0 : req0;
        cls1 = (pend0 | pend1) ? pend1 : req1;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (HREADY) begin
            if (cls0 && cls1) begin
`ifdef ARB_RR_EN
                if (rr_last_q == OWN_M0) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
`else
                gnt0 = 1'b1;
`endif
            end else if (cls0) begin
                gnt0 = 1'b1;
            end else if (cls1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        bus_haddr  = '0;
        bus_htrans = HTRANS_IDLE;
        bus_hwrite = 1'b0;
        bus_hsize  = '0;
        if (gnt0) begin
            bus_haddr  = aph_haddr0;
            bus_htrans = HTRANS_NONSEQ;
            bus_hwrite = aph_hwrite0;
            bus_hsize  = aph_hsize0;
        end else if (gnt1) begin
            bus_haddr  = aph_haddr1;
            bus_htrans = HTRANS_NONSEQ;
            bus_hwrite = aph_hwrite1;
            bus_hsize  = aph_hsize1;
        end
    end

    // While the bus stalls the address outputs repeat the last grant.
    always_comb begin
        haddr_d      = HREADY ? bus_haddr  : haddr_q;
        htrans_d     = HREADY ? bus_htrans : htrans_q;
        hwrite_d     = HREADY ? bus_hwrite : hwrite_q;
        hsize_d      = HREADY ? bus_hsize  : hsize_q;
        data_owner_d = data_owner_q;
        if (HREADY) begin
            data_owner_d = gnt0 ? OWN_M0 : (gnt1 ? OWN_M1 : OWN_NONE);
        end
    end

    assign HADDR  = haddr_d;
    assign HTRANS = htrans_d;
    assign HWRITE = hwrite_d;
    assign HSIZE  = hsize_d;

    always_comb begin
        case (data_owner_q)
            OWN_M0:  HWDATA = M0_HWDATA;
            OWN_M1:  HWDATA = M1_HWDATA;
            default: HWDATA = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_owner_q <= OWN_NONE;
            haddr_q      <= '0;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
        end else begin
            data_owner_q <= data_owner_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
        end
    end

`ifdef ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt0) begin
            rr_last_d = OWN_M0;
        end else if (gnt1) begin
            rr_last_d = OWN_M1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_last_q <= OWN_M1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// tb_ahb_lite_arb2: self-checking bench for ahb_lite_arb2.
// Each master is a transfer queue that advances whenever its private HREADY
// was high at the previous edge; a behavioural arbiter model predicts every
// bus-side and master-side output each cycle. Honours ARB_RR_EN.
module tb_ahb_lite_arb2;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef struct packed {
        logic [1:0]    trans;
        logic [AW-1:0] addr;
        logic          write;
        logic [2:0]    size;
        logic [DW-1:0] wdata;
    } xfer_t;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic [AW-1:0] m0_haddr, m1_haddr, haddr;
    logic [1:0]    m0_htrans, m1_htrans, htrans;
    logic          m0_hwrite, m1_hwrite, hwrite;
    logic [2:0]    m0_hsize, m1_hsize, hsize;
    logic [DW-1:0] m0_hwdata, m1_hwdata, hwdata;
    logic          m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [DW-1:0] m0_hrdata, m1_hrdata;
    logic          hready;
    logic [DW-1:0] hrdata;

    int total = 0;
    int bad   = 0;

    // master-side stimulus state
    xfer_t         q0[$];
    xfer_t         q1[$];
    xfer_t         cur[2];
    logic [DW-1:0] m_wdata[2];
    bit            adv[2];

    // arbiter reference model state
    bit            pend[2];
    xfer_t         held[2];
    int            owner;
    int            rr_last;
    logic [AW-1:0] hold_addr;
    logic [1:0]    hold_trans;
    logic          hold_write;
    logic [2:0]    hold_size;

    always #5 hclk = ~hclk;

    ahb_lite_arb2 #(.AW(AW), .DW(DW)) dut (
        .HCLK(hclk), .HRESETn(hresetn),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite),
        .M0_HSIZE(m0_hsize), .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready),
        .M0_HRDATA(m0_hrdata), .M0_HRESP(m0_hresp),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite),
        .M1_HSIZE(m1_hsize), .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready),
        .M1_HRDATA(m1_hrdata), .M1_HRESP(m1_hresp),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
        .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(input logic [1:0] t, input logic [AW-1:0] a,
                                 input logic w, input logic [DW-1:0] d);
        xfer_t x;
        x.trans = t; x.addr = a; x.write = w; x.size = 3'd2; x.wdata = d;
        return x;
    endfunction

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            pend[x] = 1'b0; held[x] = '0; cur[x] = '0; m_wdata[x] = '0; adv[x] = 1'b1;
        end
        owner = -1; rr_last = 1;
        hold_addr = '0; hold_trans = T_IDLE; hold_write = 1'b0; hold_size = '0;
    endtask

    task automatic advance_masters();
        for (int x = 0; x < 2; x++) begin
            if (adv[x]) begin
                m_wdata[x] = cur[x].wdata;
                cur[x] = '0;
                if (x == 0 && q0.size() > 0) cur[0] = q0.pop_front();
                if (x == 1 && q1.size() > 0) cur[1] = q1.pop_front();
            end
        end
        m0_haddr = cur[0].addr; m0_htrans = cur[0].trans; m0_hwrite = cur[0].write;
        m0_hsize = cur[0].size; m0_hwdata = m_wdata[0];
        m1_haddr = cur[1].addr; m1_htrans = cur[1].trans; m1_hwrite = cur[1].write;
        m1_hsize = cur[1].size; m1_hwdata = m_wdata[1];
    endtask

    // One bus cycle: drive at the falling edge, predict and compare 1 ns later,
    // then advance the model to the state after the next rising edge.
    task automatic step(input logic rdy);
        bit            mrdy[2];
        bit            live[2];
        bit            cand[2];
        bit            anyp;
        int            win;
        xfer_t         src;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_trans;
        logic          e_write;
        logic [2:0]    e_size;
        @(negedge hclk);
        advance_masters();
        hready = rdy;
        hrdata = {$urandom, $urandom};
        #1;
        for (int x = 0; x < 2; x++) begin
            mrdy[x] = (owner == x) ? rdy : !pend[x];
            live[x] = cur[x].trans[1] && mrdy[x];
        end
        anyp = pend[0] || pend[1];
        for (int x = 0; x < 2; x++) cand[x] = anyp ? pend[x] : live[x];
        win = -1;
        if (rdy) begin
            if (cand[0] && cand[1]) begin
`ifdef ARB_RR_EN
                win = (rr_last == 0) ? 1 : 0;
`else
                win = 0;
`endif
            end else if (cand[0]) win = 0;
            else if (cand[1]) win = 1;
        end
        if (!rdy) begin
            e_addr = hold_addr; e_trans = hold_trans; e_write = hold_write; e_size = hold_size;
        end else if (win < 0) begin
            e_addr = '0; e_trans = T_IDLE; e_write = 1'b0; e_size = '0;
        end else begin
            src = pend[win] ? held[win] : cur[win];
            e_addr = src.addr; e_trans = T_NONSEQ; e_write = src.write; e_size = src.size;
        end
        chk("haddr",  haddr,  e_addr);
        chk("htrans", htrans, e_trans);
        chk("hwrite", hwrite, e_write);
        chk("hsize",  hsize,  e_size);
        chk("hwdata", hwdata, (owner < 0) ? '0 : m_wdata[owner]);
        chk("m0_hready", m0_hready, mrdy[0]);
        chk("m1_hready", m1_hready, mrdy[1]);
        chk("m0_hrdata", m0_hrdata, hrdata);
        chk("m1_hrdata", m1_hrdata, hrdata);
        chk("hresp", {m0_hresp, m1_hresp}, 2'b00);
        if (rdy) begin
            hold_addr = e_addr; hold_trans = e_trans; hold_write = e_write; hold_size = e_size;
            owner = win;
            if (win >= 0) rr_last = win;
        end
        for (int x = 0; x < 2; x++) begin
            if (win == x) pend[x] = 1'b0;
            else if (!pend[x] && live[x]) begin
                pend[x] = 1'b1;
                held[x] = cur[x];
            end
            adv[x] = mrdy[x];
        end
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        model_reset();
        advance_masters();
        hready = 1'b1;
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
    endtask

    initial begin
        model_reset();
        advance_masters();
        hready = 1'b1;
        hrdata = '0;
        @(negedge hclk);
        #1;
        chk("rst_htrans", htrans, T_IDLE);
        chk("rst_haddr", haddr, '0);
        chk("rst_m0_hready", m0_hready, 1'b1);
        chk("rst_m1_hready", m1_hready, 1'b1);
        @(negedge hclk);
        hresetn = 1'b1;

        // 1: single uncontended read passes straight through
        q0.push_back(mk(T_NONSEQ, 32'h0000_0100, 1'b0, '0));
        step(1'b1);
        chk("t1_haddr", haddr, 32'h0000_0100);
        chk("t1_htrans", htrans, T_NONSEQ);
        step(1'b0);
        chk("t1_m0_stall", m0_hready, 1'b0);
        step(1'b1);
        chk("t1_m0_done", m0_hready, 1'b1);

        // 2: simultaneous requests, M1 buffered for exactly one cycle
        q0.push_back(mk(T_NONSEQ, 32'h0000_0010, 1'b0, '0));
        q1.push_back(mk(T_NONSEQ, 32'h2000_0000, 1'b0, '0));
        step(1'b1);
        chk("t2_first", haddr, 32'h0000_0010);
        step(1'b1);
        chk("t2_second", haddr, 32'h2000_0000);
        chk("t2_m1_stall", m1_hready, 1'b0);
        step(1'b1);
        chk("t2_m1_back", m1_hready, 1'b1);
        step(1'b1);

        // 3: M1 write buffered during a 3-cycle M0 data-phase stall
        q0.push_back(mk(T_NONSEQ, 32'h0000_0040, 1'b0, '0));
        step(1'b1);
        q1.push_back(mk(T_NONSEQ, 32'h3000_0000, 1'b1, 64'h0000_0000_DEAD_BEEF));
        repeat (3) step(1'b0);
        step(1'b1);
        chk("t3_addr", haddr, 32'h3000_0000);
        chk("t3_write", hwrite, 1'b1);
        step(1'b1);
        chk("t3_wdata", hwdata, 64'h0000_0000_DEAD_BEEF);
        step(1'b1);

        // 4: back-to-back contention alternates; then a fresh tie after M0 won
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(T_NONSEQ, 32'h100 + 32'(4 * i), 1'b0, '0));
            q1.push_back(mk(T_NONSEQ, 32'h200 + 32'(4 * i), 1'b0, '0));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            chk($sformatf("t4_grant%0d", i), haddr,
                ((i % 2) == 0) ? 32'h100 + 32'(4 * (i / 2)) : 32'h200 + 32'(4 * (i / 2)));
        end
        repeat (2) step(1'b1);
        q0.push_back(mk(T_NONSEQ, 32'h900, 1'b0, '0));
        step(1'b1);
        step(1'b1);
        q0.push_back(mk(T_NONSEQ, 32'h904, 1'b0, '0));
        q1.push_back(mk(T_NONSEQ, 32'hA00, 1'b0, '0));
        step(1'b1);
`ifdef ARB_RR_EN
        chk("t4_tie", haddr, 32'hA00);
`else
        chk("t4_tie", haddr, 32'h904);
`endif
        repeat (3) step(1'b1);

        // 5: asynchronous reset while M1 is buffered
        q0.push_back(mk(T_NONSEQ, 32'h500, 1'b0, '0));
        q1.push_back(mk(T_NONSEQ, 32'h600, 1'b0, '0));
        step(1'b1);
        @(negedge hclk);
        advance_masters();
        hready = 1'b1;
        hresetn = 1'b0;
        #1;
        chk("t5_m1_hready", m1_hready, 1'b1);
        chk("t5_htrans", htrans, T_IDLE);
        chk("t5_m0_hready", m0_hready, 1'b1);
        model_reset();
        advance_masters();
        @(negedge hclk);
        hresetn = 1'b1;

        // 6: SEQ reissued as NONSEQ, BUSY produces no transfer
        q0.push_back(mk(T_SEQ, 32'h700, 1'b0, '0));
        step(1'b1);
        chk("t6_seq", htrans, T_NONSEQ);
        chk("t6_seq_addr", haddr, 32'h700);
        q0.push_back(mk(T_BUSY, 32'h704, 1'b0, '0));
        step(1'b1);
        chk("t6_busy", htrans, T_IDLE);
        step(1'b1);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (q0.size() < 2)
                q0.push_back(mk(2'($urandom_range(0, 3)), {$urandom} & 32'hFFFF_FFFC,
                                1'($urandom), {$urandom, $urandom}));
            if (q1.size() < 2)
                q1.push_back(mk(2'($urandom_range(0, 3)), {$urandom} & 32'hFFFF_FFFC,
                                1'($urandom), {$urandom, $urandom}));
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
